multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control unit for the 16-bit multi-cycle accumulator CPU. It sequences fetch, decode, memory access, execute and write-back, and drives every load enable, memory strobe and mux select of the datapath: PC/IR/MDR registers, the 2:1 and 3:1 select muxes, the ALU and the register file.

Instruction word layout:
- opcode = IR[15:12]
- reg field = IR[11:9]
- func = IR[8:0] (one-hot)
- imm/addr = IR[11:0]

## Interface
Parameters: none; all encodings live in the shared package.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  4  IR[15:12], from the IR register.
- func  in  9  IR[8:0], one-hot R-type function.
- acc_zero  in  1  R0 == 0, from the register file read port.
- mem_ready  in  1  memory done; present only with MC_MEM_WAIT_EN.
- pc_ld  out  1  PC load enable.
- ir_ld  out  1  IR load enable.
- mdr_ld  out  1  MDR load enable.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- iord  out  1  address mux select: 0 = PC, 1 = {4'b0, IR[11:0]}.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = R0.
- alu_src_b  out  2  ALU B select: 00 = Ri, 01 = constant 1, 10 = sext(IR[11:0]).
- alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT A, 101 PASS B, 110 PASS A.
- pc_src  out  2  PC mux select: 00 = ALU result, 01 = {PC[15:12], IR[11:0]}, 10 = reserved.
- reg_wr  out  1  register file write enable.
- reg_dst  out  1  write target: 0 = R0, 1 = Ri.
- wb_src  out  1  write-back source: 0 = ALU-out register, 1 = MDR.

## Operation
- Moore FSM. Outputs decode from the state plus the IR-held opcode/func.
- Any output not listed for a state is 0.
- States and actions:
  - FETCH: mem_rd, iord=0, ir_ld, alu_src_a=0, alu_src_b=01, ADD, pc_src=00, pc_ld. Next: DECODE.
  - DECODE: no strobes. Next by opcode:
    - 0000 LOAD → LD_MEM
    - 0001 STORE → ST_MEM
    - 0010 JUMP → JMP
    - 0100 BRZ → BRZ
    - 1000 RTYPE → RT_EXE
    - 1100..1111 (ADDI/SUBI/ANDI/ORI) → IM_EXE
    - any other opcode → FETCH (NOP)
  - LD_MEM: mem_rd, iord=1, mdr_ld → LD_WB.
  - LD_WB: reg_wr, reg_dst=0, wb_src=1 → FETCH.
  - ST_MEM: mem_wr, iord=1 (data = R0) → FETCH.
  - JMP: pc_src=01, pc_ld → FETCH.
  - BRZ: pc_src=01, pc_ld=acc_zero → FETCH.
  - RT_EXE: alu_src_a=1, alu_src_b=00, alu_op from func → RT_WB.
    - func bit0 MoveTo (PASS A, reg_dst=1)
    - bit1 MoveFrom (PASS B, reg_dst=0)
    - bit2 ADD
    - bit3 SUB
    - bit4 AND
    - bit5 OR
    - bit6 NOT
    - bit7 NOP
    - All except MoveTo write R0.
  - RT_WB: same alu/reg_dst selects held, reg_wr=1, wb_src=0 → FETCH. For NOP or a non-one-hot func, reg_wr=0.
  - IM_EXE: alu_src_a=1, alu_src_b=10, alu_op = ADD/SUB/AND/OR from opcode[1:0] → IM_WB.
  - IM_WB: reg_wr, reg_dst=0, wb_src=0 → FETCH.
- The ALU-out register loads every cycle, uncontrolled. WB states write the value computed in the preceding EXE cycle.

## Timing
- rst sampled high at a rising edge: state ← FETCH.
- While rst=1, all outputs are forced to 0, so no PC/IR/memory side effects during reset.
- The first cycle after rst deasserts is FETCH.
- Reset mid-instruction abandons it. No partial write is issued after the reset edge.
- Cycles per instruction (no wait):
  - NOP/illegal: 2
  - STORE, JUMP, BRZ: 3
  - LOAD, RTYPE, IMMEDIATE: 4
- PC increments at the end of FETCH. Jump/branch target uses the incremented PC's upper nibble.

## Configuration
- MC_MEM_WAIT_EN defined:
  - The mem_ready port exists.
  - FETCH, LD_MEM and ST_MEM hold their state and strobes until mem_ready=1.
  - pc_ld, ir_ld and mdr_ld assert only in the cycle where mem_ready=1.
  - mem_ready arriving in the first cycle costs no extra latency.
- Undefined: the port is absent and each memory access takes exactly one cycle.

## Structure
- Package mc_ctrl_pkg holds:
  - state enum
  - opcode constants
  - func bit indices
  - alu_op codes
  - alu_src_b, pc_src, iord and wb_src select constants
- Sub-module alu_control: maps state class (fetch / R-type / immediate) plus opcode/func to alu_op. Combinational, instantiated once.

## Test plan
- Reset held 3 cycles mid-LD_MEM, then released: all outputs 0 during reset; the next cycle shows FETCH with mem_rd=ir_ld=pc_ld=1.
- LOAD opcode 0000: state sequence FETCH, DECODE, LD_MEM (mdr_ld=1, iord=1), LD_WB (reg_wr=1, wb_src=1); 4 cycles.
- RTYPE func=9'b000000100 (ADD): RT_EXE with alu_op=000, alu_src_b=00; RT_WB with reg_wr=1, reg_dst=0.
- RTYPE func=9'b000000011 (not one-hot): reg_wr stays 0 and control returns to FETCH after 4 cycles.
- BRZ: acc_zero=1 gives pc_ld=1 with pc_src=01; acc_zero=0 gives pc_ld=0. Opcode 0111 returns to FETCH after DECODE (2 cycles).
- With MC_MEM_WAIT_EN, mem_ready low for 2 cycles in FETCH: FETCH is held 3 cycles; ir_ld and pc_ld are high only in the 3rd cycle.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle accumulator CPU control unit: FSM states,
// opcodes, R-type function bits, ALU operations and datapath mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_LD_MEM,
        S_LD_WB,
        S_ST_MEM,
        S_JMP,
        S_BRZ,
        S_RT_EXE,
        S_RT_WB,
        S_IM_EXE,
        S_IM_WB
    } state_t;

    typedef enum logic [1:0] {
        ALU_CLASS_NONE,
        ALU_CLASS_FETCH,
        ALU_CLASS_RTYPE,
        ALU_CLASS_IMM
    } alu_class_t;

    localparam logic [3:0] OP_LOAD   = 4'b0000;
    localparam logic [3:0] OP_STORE  = 4'b0001;
    localparam logic [3:0] OP_JUMP   = 4'b0010;
    localparam logic [3:0] OP_BRZ    = 4'b0100;
    localparam logic [3:0] OP_RTYPE  = 4'b1000;
    localparam logic [1:0] OP_IMM_HI = 2'b11;

    localparam int FUNC_W        = 9;
    localparam int FUNC_MOVETO   = 0;
    localparam int FUNC_MOVEFROM = 1;
    localparam int FUNC_ADD      = 2;
    localparam int FUNC_SUB      = 3;
    localparam int FUNC_AND      = 4;
    localparam int FUNC_OR       = 5;
    localparam int FUNC_NOT      = 6;
    localparam int FUNC_NOP      = 7;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_AND    = 3'b010;
    localparam logic [2:0] ALU_OR     = 3'b011;
    localparam logic [2:0] ALU_NOT_A  = 3'b100;
    localparam logic [2:0] ALU_PASS_B = 3'b101;
    localparam logic [2:0] ALU_PASS_A = 3'b110;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_JUMP = 2'b01;
    localparam logic       IORD_PC    = 1'b0;
    localparam logic       IORD_IR    = 1'b1;
    localparam logic       WB_ALU     = 1'b0;
    localparam logic       WB_MDR     = 1'b1;
    localparam logic       REGDST_R0  = 1'b0;
    localparam logic       REGDST_RI  = 1'b1;

    typedef struct packed {
        logic       pc_ld;
        logic       ir_ld;
        logic       mdr_ld;
        logic       mem_rd;
        logic       mem_wr;
        logic       iord;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       reg_wr;
        logic       reg_dst;
        logic       wb_src;
    } ctrl_t;

    // Only a one-hot func selecting a real operation (MoveTo..NOT) writes back.
    function automatic logic func_writes(input logic [FUNC_W-1:0] f);
        return (f != '0) && ((f & (f - 9'd1)) == '0) && ((f >> FUNC_NOP) == '0);
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_control.sv
// ALU operation decode: fetch increments the PC, R-type decodes the one-hot func,
// immediates use opcode[1:0].
module alu_control
    import mc_ctrl_pkg::*;
(
    input  alu_class_t         alu_class,
    input  logic [1:0]         imm_op,
    input  logic [FUNC_W-1:0]  func,
    output logic [2:0]         alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (alu_class)
            ALU_CLASS_RTYPE: begin
                case (func)
                    9'd1 << FUNC_MOVETO:   alu_op = ALU_PASS_A;
                    9'd1 << FUNC_MOVEFROM: alu_op = ALU_PASS_B;
                    9'd1 << FUNC_ADD:      alu_op = ALU_ADD;
                    9'd1 << FUNC_SUB:      alu_op = ALU_SUB;
                    9'd1 << FUNC_AND:      alu_op = ALU_AND;
                    9'd1 << FUNC_OR:       alu_op = ALU_OR;
                    9'd1 << FUNC_NOT:      alu_op = ALU_NOT_A;
                    default:               alu_op = ALU_ADD;
                endcase
            end
            ALU_CLASS_IMM: begin
                case (imm_op)
                    2'b00:   alu_op = ALU_ADD;
                    2'b01:   alu_op = ALU_SUB;
                    2'b10:   alu_op = ALU_AND;
                    default: alu_op = ALU_OR;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the 16-bit multi-cycle accumulator CPU.
// Optional build macro MC_MEM_WAIT_EN adds mem_ready and stalls memory states on it.
module multicycle_controller
    import mc_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        opcode,
    input  logic [FUNC_W-1:0] func,
    input  logic              acc_zero,
`ifdef MC_MEM_WAIT_EN
    input  logic              mem_ready,
`endif
    output logic              pc_ld,
    output logic              ir_ld,
    output logic              mdr_ld,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              iord,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [2:0]        alu_op,
    output logic [1:0]        pc_src,
    output logic              reg_wr,
    output logic              reg_dst,
    output logic              wb_src
);

    state_t     state_q, state_d;
    ctrl_t      ctrl, ctrl_out;
    alu_class_t alu_class;
    logic [2:0] alu_op_w;
    logic       mem_done;

`ifdef MC_MEM_WAIT_EN
    assign mem_done = mem_ready;
`else
    assign mem_done = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_rd    = 1'b1;
                ctrl.iord      = IORD_PC;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_ONE;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.ir_ld     = mem_done;
                ctrl.pc_ld     = mem_done;
                if (mem_done) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (opcode[3:2] == OP_IMM_HI) begin
                    state_d = S_IM_EXE;
                end else begin
                    case (opcode)
                        OP_LOAD:  state_d = S_LD_MEM;
                        OP_STORE: state_d = S_ST_MEM;
                        OP_JUMP:  state_d = S_JMP;
                        OP_BRZ:   state_d = S_BRZ;
                        OP_RTYPE: state_d = S_RT_EXE;
                        default:  state_d = S_FETCH;
                    endcase
                end
            end
            S_LD_MEM: begin
                ctrl.mem_rd = 1'b1;
                ctrl.iord   = IORD_IR;
                ctrl.mdr_ld = mem_done;
                if (mem_done) state_d = S_LD_WB;
            end
            S_LD_WB: begin
                ctrl.reg_wr  = 1'b1;
                ctrl.reg_dst = REGDST_R0;
                ctrl.wb_src  = WB_MDR;
                state_d      = S_FETCH;
            end
            S_ST_MEM: begin
                ctrl.mem_wr = 1'b1;
                ctrl.iord   = IORD_IR;
                if (mem_done) state_d = S_FETCH;
            end
            S_JMP: begin
                ctrl.pc_src = PCSRC_JUMP;
                ctrl.pc_ld  = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRZ: begin
                ctrl.pc_src = PCSRC_JUMP;
                ctrl.pc_ld  = acc_zero;
                state_d     = S_FETCH;
            end
            S_RT_EXE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.reg_dst   = (func == (9'd1 << FUNC_MOVETO)) ? REGDST_RI : REGDST_R0;
                state_d        = S_RT_WB;
            end
            S_RT_WB: begin
                // Selects stay as in RT_EXE so the write target matches the computed value.
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.reg_dst   = (func == (9'd1 << FUNC_MOVETO)) ? REGDST_RI : REGDST_R0;
                ctrl.reg_wr    = func_writes(func);
                ctrl.wb_src    = WB_ALU;
                state_d        = S_FETCH;
            end
            S_IM_EXE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_d        = S_IM_WB;
            end
            S_IM_WB: begin
                ctrl.reg_wr  = 1'b1;
                ctrl.reg_dst = REGDST_R0;
                ctrl.wb_src  = WB_ALU;
                state_d      = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        alu_class = ALU_CLASS_NONE;
        case (state_q)
            S_FETCH:           alu_class = ALU_CLASS_FETCH;
            S_RT_EXE, S_RT_WB: alu_class = ALU_CLASS_RTYPE;
            S_IM_EXE:          alu_class = ALU_CLASS_IMM;
            default:           alu_class = ALU_CLASS_NONE;
        endcase
    end

    alu_control u_alu_control (
        .alu_class (alu_class),
        .imm_op    (opcode[1:0]),
        .func      (func),
        .alu_op    (alu_op_w)
    );

    // Reset blanks every strobe combinationally so nothing fires while rst is high.
    assign ctrl_out  = rst ? '0 : ctrl;
    assign alu_op    = rst ? ALU_ADD : alu_op_w;
    assign pc_ld     = ctrl_out.pc_ld;
    assign ir_ld     = ctrl_out.ir_ld;
    assign mdr_ld    = ctrl_out.mdr_ld;
    assign mem_rd    = ctrl_out.mem_rd;
    assign mem_wr    = ctrl_out.mem_wr;
    assign iord      = ctrl_out.iord;
    assign alu_src_a = ctrl_out.alu_src_a;
    assign alu_src_b = ctrl_out.alu_src_b;
    assign pc_src    = ctrl_out.pc_src;
    assign reg_wr    = ctrl_out.reg_wr;
    assign reg_dst   = ctrl_out.reg_dst;
    assign wb_src    = ctrl_out.wb_src;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed table, reset and
// wait-state sequences, and random instructions against an instruction-level model.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic [8:0] func;
    logic       acc_zero;
    logic       mem_ready;
    logic       pc_ld, ir_ld, mdr_ld, mem_rd, mem_wr, iord, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;
    logic       reg_wr, reg_dst, wb_src;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .func      (func),
        .acc_zero  (acc_zero),
`ifdef MC_MEM_WAIT_EN
        .mem_ready (mem_ready),
`endif
        .pc_ld     (pc_ld),
        .ir_ld     (ir_ld),
        .mdr_ld    (mdr_ld),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .iord      (iord),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .pc_src    (pc_src),
        .reg_wr    (reg_wr),
        .reg_dst   (reg_dst),
        .wb_src    (wb_src)
    );

    // Output vector: {pc_ld, ir_ld, mdr_ld, mem_rd, mem_wr, iord, src_a, src_b, alu_op, pc_src, reg_wr, reg_dst, wb_src}
    logic [16:0] dut_v;
    assign dut_v = {pc_ld, ir_ld, mdr_ld, mem_rd, mem_wr, iord, alu_src_a,
                    alu_src_b, alu_op, pc_src, reg_wr, reg_dst, wb_src};

    int errors = 0;
    int checks = 0;

    function automatic logic [16:0] mk(input bit pl, input bit il, input bit ml,
                                       input bit mr, input bit mw, input bit io,
                                       input bit sa, input bit [1:0] sb,
                                       input bit [2:0] ao, input bit [1:0] ps,
                                       input bit rw, input bit rd, input bit wb);
        return {pl, il, ml, mr, mw, io, sa, sb, ao, ps, rw, rd, wb};
    endfunction

    logic [16:0] fetch_v;

    task automatic chk(input logic [16:0] got, input logic [16:0] exp, input string name);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", name, got, exp);
        end else begin
            $display("ok   %s: %05h", name, got);
        end
    endtask

    task automatic chk_int(input int got, input int exp, input string name);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end else begin
            $display("ok   %s: %0d", name, got);
        end
    endtask

    // Observed vectors for one instruction; index 0 is the FETCH cycle already seen.
    logic [16:0] obs_v [0:9];
    logic [16:0] exp_v [0:9];

    // Entered and left at the negedge of a FETCH cycle whose outputs were seen.
    task automatic run_instr(input logic [3:0] op, input logic [8:0] fn, input logic az,
                             output int cpi);
        opcode   = op;
        func     = fn;
        acc_zero = az;
        obs_v[0] = fetch_v;
        cpi = 9;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (dut_v == fetch_v) begin
                cpi = c;
                break;
            end
            obs_v[c] = dut_v;
        end
    endtask

    // Instruction-level reference: per-cycle outputs straight from the opcode rules.
    task automatic model(input logic [3:0] op, input logic [8:0] fn, input logic az,
                         output int n);
        logic [2:0] rop;
        logic       rdst, rwr;
        logic [2:0] ops [0:4];
        ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b011; ops[4] = 3'b100;
        for (int i = 0; i < 10; i++) exp_v[i] = '0;
        exp_v[0] = fetch_v;
        n = 2;
        if (op[3:2] == 2'b11) begin
            n = 4;
            exp_v[2] = mk(0,0,0,0,0,0,1,2'b10,{1'b0, op[1:0]},0,0,0,0);
            exp_v[3] = mk(0,0,0,0,0,0,0,0,0,0,1,0,0);
        end else if (op == 4'd0) begin
            n = 4;
            exp_v[2] = mk(0,0,1,1,0,1,0,0,0,0,0,0,0);
            exp_v[3] = mk(0,0,0,0,0,0,0,0,0,0,1,0,1);
        end else if (op == 4'd1) begin
            n = 3;
            exp_v[2] = mk(0,0,0,0,1,1,0,0,0,0,0,0,0);
        end else if (op == 4'd2) begin
            n = 3;
            exp_v[2] = mk(1,0,0,0,0,0,0,0,0,2'b01,0,0,0);
        end else if (op == 4'd4) begin
            n = 3;
            exp_v[2] = mk(az,0,0,0,0,0,0,0,0,2'b01,0,0,0);
        end else if (op == 4'd8) begin
            n = 4;
            rop = 3'b000; rdst = 1'b0; rwr = 1'b0;
            if ($countones(fn) == 1) begin
                for (int k = 0; k < 9; k++) begin
                    if (fn[k]) begin
                        if (k == 0) begin rop = 3'b110; rdst = 1'b1; rwr = 1'b1; end
                        else if (k == 1) begin rop = 3'b101; rwr = 1'b1; end
                        else if (k <= 6) begin rop = ops[k-2]; rwr = 1'b1; end
                    end
                end
            end
            exp_v[2] = mk(0,0,0,0,0,0,1,2'b00,rop,0,0,rdst,0);
            exp_v[3] = mk(0,0,0,0,0,0,1,2'b00,rop,0,rwr,rdst,0);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [8:0]  fn;
        logic        az;
        int          cpi;
        logic [16:0] prev;
        logic [16:0] last;
    } vec_t;

    vec_t tbl [0:14];

    initial begin
        int cpi, n;
        logic [3:0] rop_op;
        logic [8:0] rfn;
        logic       raz;

        fetch_v = mk(1,1,0,1,0,0,0,2'b01,3'b000,2'b00,0,0,0);
        tbl[0]  = '{4'b0000, 9'h000, 1'b0, 4, mk(0,0,1,1,0,1,0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0,0,0,0,1,0,1)};
        tbl[1]  = '{4'b0001, 9'h000, 1'b0, 3, 17'h0, mk(0,0,0,0,1,1,0,0,0,0,0,0,0)};
        tbl[2]  = '{4'b0010, 9'h000, 1'b0, 3, 17'h0, mk(1,0,0,0,0,0,0,0,0,2'b01,0,0,0)};
        tbl[3]  = '{4'b0100, 9'h000, 1'b1, 3, 17'h0, mk(1,0,0,0,0,0,0,0,0,2'b01,0,0,0)};
        tbl[4]  = '{4'b0100, 9'h000, 1'b0, 3, 17'h0, mk(0,0,0,0,0,0,0,0,0,2'b01,0,0,0)};
        tbl[5]  = '{4'b1000, 9'h004, 1'b0, 4, mk(0,0,0,0,0,0,1,0,3'b000,0,0,0,0), mk(0,0,0,0,0,0,1,0,3'b000,0,1,0,0)};
        tbl[6]  = '{4'b1000, 9'h003, 1'b0, 4, mk(0,0,0,0,0,0,1,0,3'b000,0,0,0,0), mk(0,0,0,0,0,0,1,0,3'b000,0,0,0,0)};
        tbl[7]  = '{4'b1000, 9'h001, 1'b0, 4, mk(0,0,0,0,0,0,1,0,3'b110,0,0,1,0), mk(0,0,0,0,0,0,1,0,3'b110,0,1,1,0)};
        tbl[8]  = '{4'b1000, 9'h008, 1'b0, 4, mk(0,0,0,0,0,0,1,0,3'b001,0,0,0,0), mk(0,0,0,0,0,0,1,0,3'b001,0,1,0,0)};
        tbl[9]  = '{4'b1000, 9'h040, 1'b0, 4, mk(0,0,0,0,0,0,1,0,3'b100,0,0,0,0), mk(0,0,0,0,0,0,1,0,3'b100,0,1,0,0)};
        tbl[10] = '{4'b1000, 9'h080, 1'b0, 4, mk(0,0,0,0,0,0,1,0,3'b000,0,0,0,0), mk(0,0,0,0,0,0,1,0,3'b000,0,0,0,0)};
        tbl[11] = '{4'b1100, 9'h000, 1'b0, 4, mk(0,0,0,0,0,0,1,2'b10,3'b000,0,0,0,0), mk(0,0,0,0,0,0,0,0,0,0,1,0,0)};
        tbl[12] = '{4'b1111, 9'h000, 1'b0, 4, mk(0,0,0,0,0,0,1,2'b10,3'b011,0,0,0,0), mk(0,0,0,0,0,0,0,0,0,0,1,0,0)};
        tbl[13] = '{4'b0111, 9'h000, 1'b0, 2, fetch_v, 17'h0};
        tbl[14] = '{4'b0011, 9'h000, 1'b1, 2, fetch_v, 17'h0};

        rst = 1'b1; opcode = '0; func = '0; acc_zero = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(dut_v, 17'h0, "reset_hold");
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk(dut_v, fetch_v, "first_fetch");

        for (int i = 0; i < 15; i++) begin
            run_instr(tbl[i].op, tbl[i].fn, tbl[i].az, cpi);
            chk_int(cpi, tbl[i].cpi, $sformatf("tbl%0d_cpi", i));
            if (cpi == tbl[i].cpi) begin
                chk(obs_v[cpi-2], tbl[i].prev, $sformatf("tbl%0d_prev", i));
                chk(obs_v[cpi-1], tbl[i].last, $sformatf("tbl%0d_last", i));
            end
        end

        // Reset asserted in LD_MEM and held across three clock edges.
        opcode = 4'b0000;
        @(negedge clk);
        chk(dut_v, 17'h0, "ldrst_decode");
        @(negedge clk);
        chk(dut_v, mk(0,0,1,1,0,1,0,0,0,0,0,0,0), "ldrst_ld_mem");
        rst = 1'b1;
        #1 chk(dut_v, 17'h0, "ldrst_blank");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(dut_v, 17'h0, "ldrst_hold");
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk(dut_v, fetch_v, "ldrst_fetch");
        run_instr(4'b0010, 9'h000, 1'b0, cpi);
        chk_int(cpi, 3, "ldrst_next_jump_cpi");

`ifdef MC_MEM_WAIT_EN
        opcode = 4'b0111;
        @(negedge clk);
        chk(dut_v, 17'h0, "wait_decode");
        @(posedge clk); #1 mem_ready = 1'b0;
        @(negedge clk);
        chk(dut_v, mk(0,0,0,1,0,0,0,2'b01,0,0,0,0,0), "wait_fetch1");
        @(negedge clk);
        chk(dut_v, mk(0,0,0,1,0,0,0,2'b01,0,0,0,0,0), "wait_fetch2");
        @(posedge clk); #1 mem_ready = 1'b1;
        @(negedge clk);
        chk(dut_v, fetch_v, "wait_fetch3");
        run_instr(4'b0001, 9'h000, 1'b0, cpi);
        chk_int(cpi, 3, "wait_next_store_cpi");
`endif

        for (int t = 0; t < 200; t++) begin
            rop_op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) rfn = 9'd1 << $urandom_range(0, 8);
            else rfn = 9'($urandom);
            raz = 1'($urandom);
            model(rop_op, rfn, raz, n);
            run_instr(rop_op, rfn, raz, cpi);
            chk_int(cpi, n, $sformatf("rnd%0d_op%h_fn%03h_cpi", t, rop_op, rfn));
            if (cpi == n) begin
                for (int c = 1; c < n; c++) begin
                    chk(obs_v[c], exp_v[c], $sformatf("rnd%0d_op%h_fn%03h_az%0d_c%0d", t, rop_op, rfn, raz, c));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
